// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller; per-source edge/level pending with claim/complete.
// Latency: irq_i rise -> interrupt_o in 4 edges (2-flop sync + edge detect + pending + output reg); reads 1 cycle.
// Backpressure: none; register reads and writes are accepted every cycle.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   irq_i[IRQ_COUNT]        asynchronous peripheral request lines
//   read_addr_i/_enable_i   register read port, read_data_o registered
//   write_addr_i/_data_i/_enable_i  register write port
//   interrupt_o             registered request to the CPU
// Register map (word index): 0 ENABLE, 1 PENDING (W1C edge bits), 2 TRIGGER (1=edge), 3 CLAIM.
module irq_ctrl #(
  parameter int IRQ_COUNT = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [IRQ_COUNT-1:0] irq_i,
  input  logic [1:0]           read_addr_i,
  input  logic                 read_enable_i,
  output logic [31:0]          read_data_o,
  input  logic [1:0]           write_addr_i,
  input  logic [31:0]          write_data_i,
  input  logic                 write_enable_i,
  output logic                 interrupt_o
);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_TRIGGER = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  logic [IRQ_COUNT-1:0] r_s1;
  logic [IRQ_COUNT-1:0] r_s2;
  logic [IRQ_COUNT-1:0] r_s3;
  logic [IRQ_COUNT-1:0] r_enable;
  logic [IRQ_COUNT-1:0] r_trigger;
  logic [IRQ_COUNT-1:0] r_pending;
  logic [IRQ_COUNT-1:0] r_in_service;
  logic [31:0]          r_read_data;
  logic                 r_interrupt;

  logic [IRQ_COUNT-1:0] w_edge;
  logic [IRQ_COUNT-1:0] w_eligible;
  logic [IRQ_COUNT-1:0] w_claim_onehot;
  logic [IRQ_COUNT-1:0] w_complete;
  logic [IRQ_COUNT-1:0] w_w1c;
  logic [IRQ_COUNT-1:0] w_edge_clr;
  logic [IRQ_COUNT-1:0] w_pending_nxt;
  logic [IRQ_COUNT-1:0] w_in_service_nxt;
  logic [4:0]           w_claim_id;
  logic [31:0]          w_read_mux;
  logic                 w_claim_rd;
  logic                 w_wr_enable;
  logic                 w_wr_trigger;
  logic                 w_wr_pending;
  logic                 w_wr_claim;
  logic                 w_unused_wdata;

  assign w_edge     = r_s2 & ~r_s3;
  // Everything below works on pre-write register state, so a same-cycle
  // write never influences a claim.
  assign w_eligible = r_pending & r_enable & ~r_in_service;

  assign w_claim_rd   = read_enable_i  && (read_addr_i  == ADDR_CLAIM);
  assign w_wr_enable  = write_enable_i && (write_addr_i == ADDR_ENABLE);
  assign w_wr_pending = write_enable_i && (write_addr_i == ADDR_PENDING);
  assign w_wr_trigger = write_enable_i && (write_addr_i == ADDR_TRIGGER);
  assign w_wr_claim   = write_enable_i && (write_addr_i == ADDR_CLAIM);

  // Upper write-data bits beyond the implemented sources are don't-care.
  assign w_unused_wdata = ^write_data_i;

  // Lowest-numbered eligible source wins: scan high to low, last hit sticks.
  always_comb begin
    w_claim_id     = 5'd0;
    w_claim_onehot = '0;
    for (int k = IRQ_COUNT - 1; k >= 0; k--) begin
      if (w_eligible[k]) begin
        w_claim_id     = 5'(k + 1);
        w_claim_onehot = '0;
        w_claim_onehot[k] = w_claim_rd;
      end
    end
  end

  // Complete decode; ids 0 and > IRQ_COUNT match nothing, and clearing a bit
  // that is not in service is a no-op.
  always_comb begin
    w_complete = '0;
    if (w_wr_claim) begin
      for (int k = 0; k < IRQ_COUNT; k++) begin
        if (write_data_i[4:0] == 5'(k + 1)) begin
          w_complete[k] = 1'b1;
        end
      end
    end
  end

  // W1C only touches edge-mode bits; a new edge beats any clear in the same cycle.
  assign w_w1c      = w_wr_pending ? (write_data_i[IRQ_COUNT-1:0] & r_trigger) : '0;
  assign w_edge_clr = w_w1c | (w_claim_onehot & r_trigger);
  assign w_pending_nxt = (r_trigger  & ((r_pending & ~w_edge_clr) | w_edge))
                       | (~r_trigger & r_s2);

  // Old in_service gates the claim, so complete+claim of one id only completes.
  assign w_in_service_nxt = (r_in_service & ~w_complete) | w_claim_onehot;

  always_comb begin
    w_read_mux = 32'd0;
    if (read_enable_i) begin
      case (read_addr_i)
        ADDR_ENABLE:  w_read_mux = 32'(r_enable);
        ADDR_PENDING: w_read_mux = 32'(r_pending);
        ADDR_TRIGGER: w_read_mux = 32'(r_trigger);
        ADDR_CLAIM:   w_read_mux = 32'(w_claim_id);
        default:      w_read_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_s3         <= '0;
      r_enable     <= '0;
      r_trigger    <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_read_data  <= 32'd0;
      r_interrupt  <= 1'b0;
    end else begin
      r_s1         <= irq_i;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
      r_read_data  <= w_read_mux;
      r_interrupt  <= |w_eligible;
      if (w_wr_enable) begin
        r_enable <= write_data_i[IRQ_COUNT-1:0];
      end
      if (w_wr_trigger) begin
        r_trigger <= write_data_i[IRQ_COUNT-1:0];
      end
    end
  end

  assign read_data_o = r_read_data;
  assign interrupt_o = r_interrupt;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [7:0]  irq_i = 8'd0;
  logic [1:0]  read_addr_i = 2'd0;
  logic        read_enable_i = 1'b0;
  logic [31:0] read_data_o;
  logic [1:0]  write_addr_i = 2'd0;
  logic [31:0] write_data_i = 32'd0;
  logic        write_enable_i = 1'b0;
  logic        interrupt_o;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl #(.IRQ_COUNT(8)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .irq_i          (irq_i),
    .read_addr_i    (read_addr_i),
    .read_enable_i  (read_enable_i),
    .read_data_o    (read_data_o),
    .write_addr_i   (write_addr_i),
    .write_data_i   (write_data_i),
    .write_enable_i (write_enable_i),
    .interrupt_o    (interrupt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    read_addr_i   = a;
    read_enable_i = 1'b1;
    tick();
    read_enable_i = 1'b0;
    chk(tag, read_data_o, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write_addr_i   = a;
    write_data_i   = d;
    write_enable_i = 1'b1;
    tick();
    write_enable_i = 1'b0;
    write_data_i   = 32'd0;
  endtask

  task automatic pulse0();
    irq_i[0] = 1'b1;
    tick();
    irq_i[0] = 1'b0;
  endtask

  initial begin
    // Reset state
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_intr", {31'd0, interrupt_o}, 32'd0);
    chk("rst_rdata", read_data_o, 32'd0);
    rd_chk("rst_enable", 2'd0, 32'd0);
    rd_chk("rst_trigger", 2'd2, 32'd0);
    rd_chk("rst_pending", 2'd1, 32'd0);

    // Edge source 0: latency from sampling edge N to interrupt_o
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h1);
    rd_chk("enable_rb", 2'd0, 32'h1);
    irq_i[0] = 1'b1;
    tick();                                   // edge N
    irq_i[0] = 1'b0;
    chk("lat_n0", {31'd0, interrupt_o}, 32'd0);
    tick();                                   // N+1
    chk("lat_n1", {31'd0, interrupt_o}, 32'd0);
    tick();                                   // N+2
    chk("lat_n2", {31'd0, interrupt_o}, 32'd0);
    tick();                                   // N+3
    chk("lat_n3", {31'd0, interrupt_o}, 32'd1);
    rd_chk("pending_src0", 2'd1, 32'h1);
    rd_chk("claim_src0", 2'd3, 32'd1);
    chk("intr_claim_m", {31'd0, interrupt_o}, 32'd1);
    tick();
    chk("intr_claim_m1", {31'd0, interrupt_o}, 32'd0);
    wr(2'd3, 32'd1);

    // Sources 2 and 5: priority order of claims
    wr(2'd0, 32'h25);
    wr(2'd2, 32'h25);
    irq_i[2] = 1'b1;
    irq_i[5] = 1'b1;
    repeat (4) tick();
    chk("intr_2_5", {31'd0, interrupt_o}, 32'd1);
    rd_chk("claim_id3", 2'd3, 32'd3);
    rd_chk("claim_id6", 2'd3, 32'd6);
    chk("intr_claim2_m", {31'd0, interrupt_o}, 32'd1);
    rd_chk("claim_none", 2'd3, 32'd0);
    chk("intr_claim2_m1", {31'd0, interrupt_o}, 32'd0);
    tick();
    chk("rdata_idle", read_data_o, 32'd0);
    wr(2'd3, 32'd3);
    wr(2'd3, 32'd6);
    irq_i = 8'd0;
    repeat (3) tick();
    chk("intr_held_no_edge", {31'd0, interrupt_o}, 32'd0);
    rd_chk("pending_empty", 2'd1, 32'd0);

    // Level source 1: claim, bogus completes, real complete
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h2);
    irq_i[1] = 1'b1;
    repeat (4) tick();
    chk("intr_lvl", {31'd0, interrupt_o}, 32'd1);
    rd_chk("claim_lvl", 2'd3, 32'd2);
    tick();
    chk("intr_lvl_claimed", {31'd0, interrupt_o}, 32'd0);
    rd_chk("pending_lvl", 2'd1, 32'h2);
    wr(2'd3, 32'd7);
    wr(2'd3, 32'd0);
    tick();
    chk("cpl_bogus", {31'd0, interrupt_o}, 32'd0);
    rd_chk("claim_while_isr", 2'd3, 32'd0);
    wr(2'd3, 32'd2);
    chk("cpl_lvl_m", {31'd0, interrupt_o}, 32'd0);
    tick();
    chk("cpl_lvl_m1", {31'd0, interrupt_o}, 32'd1);
    wr(2'd1, 32'h2);
    rd_chk("w1c_level_ignored", 2'd1, 32'h2);
    irq_i[1] = 1'b0;
    repeat (3) tick();
    rd_chk("pending_lvl_drop", 2'd1, 32'd0);
    chk("intr_lvl_drop", {31'd0, interrupt_o}, 32'd0);

    // Edge source 0 re-pends while in service
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h1);
    pulse0();
    repeat (3) tick();
    rd_chk("claim_e0", 2'd3, 32'd1);
    pulse0();
    repeat (3) tick();
    rd_chk("repend_isr", 2'd1, 32'h1);
    chk("intr_isr_masked", {31'd0, interrupt_o}, 32'd0);
    wr(2'd3, 32'd1);
    chk("cpl_e0_m", {31'd0, interrupt_o}, 32'd0);
    tick();
    chk("cpl_e0_m1", {31'd0, interrupt_o}, 32'd1);
    rd_chk("reclaim_e0", 2'd3, 32'd1);
    wr(2'd3, 32'd1);

    // W1C in the same cycle as a new edge: the set wins
    irq_i[0] = 1'b1;
    tick();                                   // edge N
    irq_i[0] = 1'b0;
    tick();                                   // N+1
    wr(2'd1, 32'h1);                          // N+2, edge sets pending here
    rd_chk("w1c_vs_edge", 2'd1, 32'h1);
    wr(2'd1, 32'h1);
    rd_chk("w1c_edge_clear", 2'd1, 32'h0);

    // Reset mid-service abandons the claim
    pulse0();
    repeat (3) tick();
    rd_chk("claim_pre_rst", 2'd3, 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("rst2_intr", {31'd0, interrupt_o}, 32'd0);
    chk("rst2_rdata", read_data_o, 32'd0);
    rd_chk("rst2_enable", 2'd0, 32'd0);
    rd_chk("rst2_trigger", 2'd2, 32'd0);
    rd_chk("rst2_pending", 2'd1, 32'd0);
    rd_chk("rst2_claim", 2'd3, 32'd0);
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h1);
    pulse0();
    repeat (3) tick();
    chk("rst2_intr_again", {31'd0, interrupt_o}, 32'd1);
    rd_chk("rst2_reclaim", 2'd3, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
